// File: rtl/ddr3_ctrl_pkg.sv
// Shared DDR3 controller definitions: refresh scheduler state encoding,
// default timing constants and the width of the owed-refresh counter.
package ddr3_ctrl_pkg;

    // Default DDR3 timing, in controller clock cycles (100 MHz).
    localparam int TREFI_DEFAULT        = 780;
    localparam int TRFC_DEFAULT         = 10;
    localparam int MAX_POSTPONE_DEFAULT = 8;

    // PENDING counts 0..MAX_POSTPONE+1.
    localparam int PENDING_W = 4;

    typedef enum logic [2:0] {
        S_READY = 3'd0,
        S_PRE   = 3'd1,
        S_WAIT  = 3'd2,
        S_REF   = 3'd3,
        S_TRFC  = 3'd4
    } ref_state_t;

endpackage

// File: rtl/ddr3_refresh_scheduler_if.sv
// Handshake between the DDR3 command state machine (master) and the
// refresh scheduler (slave): controller status in, refresh requests out.
interface ddr3_refresh_scheduler_if;
    import ddr3_ctrl_pkg::*;

    logic                 INIT_DONE;
    logic                 IDLE;
    logic                 BANK_OPEN;
    logic                 REF;
    logic                 PRE;
    logic                 REF_BLOCK;
    logic [PENDING_W-1:0] PENDING;
    logic                 REF_ERR;

    modport master (
        output INIT_DONE, IDLE, BANK_OPEN,
        input  REF, PRE, REF_BLOCK, PENDING, REF_ERR
    );

    modport slave (
        input  INIT_DONE, IDLE, BANK_OPEN,
        output REF, PRE, REF_BLOCK, PENDING, REF_ERR
    );

endinterface

// File: rtl/ddr3_refi_timer.sv
// tREFI interval timer: counts 0..TREFI-1 while enabled and emits a
// one-cycle tick in the cycle that wraps back to 0. Disabled means held at 0.
module ddr3_refi_timer #(
    parameter int TREFI = 780
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam logic [CW-1:0] LAST = CW'(TREFI - 1);

    logic [CW-1:0] r_cnt;

    // Wrap counter, cleared whenever the enable drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/ddr3_refresh_scheduler.sv
// DDR3 refresh scheduler: counts owed refreshes, issues REF while the
// controller idles, and forces PRE + REF (blocking new activates) once the
// owed count reaches the urgent level.
// Build option: define REF_POSTPONE_EN to allow postponement up to
// MAX_POSTPONE refreshes; without it every tick is treated as urgent.
module ddr3_refresh_scheduler
    import ddr3_ctrl_pkg::*;
#(
    parameter int TREFI        = TREFI_DEFAULT,
    parameter int TRFC         = TRFC_DEFAULT,
    parameter int MAX_POSTPONE = MAX_POSTPONE_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      RESET,
    ddr3_refresh_scheduler_if.slave   bus
);

`ifdef REF_POSTPONE_EN
    localparam int URGENT_LVL = MAX_POSTPONE;
`else
    localparam int URGENT_LVL = 1;
`endif
    localparam int SAT_LVL = URGENT_LVL + 1;

    localparam logic [PENDING_W-1:0] URGENT_P = PENDING_W'(URGENT_LVL);
    localparam logic [PENDING_W-1:0] SAT_P    = PENDING_W'(SAT_LVL);

    // An out-of-range configuration would wrap PENDING or the timers, so such
    // an instance never starts counting intervals instead.
    localparam bit CFG_OK = (TREFI >= 4) && (TRFC >= 2) && (MAX_POSTPONE >= 1)
                         && (MAX_POSTPONE + 1 < (1 << PENDING_W));

    localparam int            TW        = (TRFC > 1) ? $clog2(TRFC) : 1;
    localparam logic [TW-1:0] TRFC_LOAD = TW'(TRFC - 1);

    ref_state_t           r_state;
    logic [TW-1:0]        r_trfc_cnt;
    logic                 r_ref;
    logic                 r_pre;
    logic [PENDING_W-1:0] r_pending;
    logic                 r_err;

    logic w_tick;
    logic w_timer_en;
    logic w_in_ref;
    logic w_urgent;
    logic w_pending_nz;

    assign w_timer_en   = bus.INIT_DONE && CFG_OK;
    assign w_in_ref     = (r_state == S_REF);
    assign w_urgent     = (r_pending >= URGENT_P);
    assign w_pending_nz = (r_pending != '0);

    ddr3_refi_timer #(
        .TREFI (TREFI)
    ) u_refi_timer (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_en    (w_timer_en),
        .o_tick  (w_tick)
    );

    // Owed-refresh counter: tick adds, the REF cycle retires one, both cancel.
    // A tick that cannot be counted is lost and latches the sticky error.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else if (w_tick && !w_in_ref) begin
            if (r_pending == SAT_P) begin
                r_err <= 1'b1;
            end else begin
                r_pending <= r_pending + PENDING_W'(1);
            end
        end else if (w_in_ref && !w_tick && w_pending_nz) begin
            r_pending <= r_pending - PENDING_W'(1);
        end
    end

    // Scheduler FSM with registered one-cycle REF/PRE pulses and the tRFC
    // hold-off. REF cycle plus S_TRFC span TRFC cycles, so idle back-to-back
    // refreshes land TRFC+1 cycles apart.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_READY;
            r_trfc_cnt <= '0;
            r_ref      <= 1'b0;
            r_pre      <= 1'b0;
        end else begin
            r_ref <= 1'b0;
            r_pre <= 1'b0;
            case (r_state)
                S_READY: begin
                    if (w_pending_nz && bus.IDLE) begin
                        r_state <= S_REF;
                        r_ref   <= 1'b1;
                    end else if (w_urgent && bus.BANK_OPEN) begin
                        r_state <= S_PRE;
                        r_pre   <= 1'b1;
                    end else if (w_urgent) begin
                        r_state <= S_WAIT;
                    end
                end
                S_PRE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.IDLE) begin
                        r_state <= S_REF;
                        r_ref   <= 1'b1;
                    end
                end
                S_REF: begin
                    r_trfc_cnt <= TRFC_LOAD;
                    r_state    <= S_TRFC;
                end
                S_TRFC: begin
                    if (r_trfc_cnt <= TW'(1)) begin
                        r_trfc_cnt <= '0;
                        r_state    <= S_READY;
                    end else begin
                        r_trfc_cnt <= r_trfc_cnt - TW'(1);
                    end
                end
                default: begin
                    r_state <= S_READY;
                end
            endcase
        end
    end

    assign bus.REF       = r_ref;
    assign bus.PRE       = r_pre;
    assign bus.REF_BLOCK = (r_state == S_PRE) || (r_state == S_WAIT)
                        || ((r_state == S_READY) && w_urgent);
    assign bus.PENDING   = r_pending;
    assign bus.REF_ERR   = r_err;

endmodule

// File: tb/tb_ddr3_refresh_scheduler.sv
// Scoreboard bench for ddr3_refresh_scheduler: a timestamp-based reference
// model pushes expected REF/PRE pulses, a monitor pops them as they appear.
`timescale 1ns/1ps
module tb_ddr3_refresh_scheduler;
    import ddr3_ctrl_pkg::*;

    localparam int TREFI        = 20;
    localparam int TRFC         = 10;
    localparam int MAX_POSTPONE = 8;
`ifdef REF_POSTPONE_EN
    localparam int URG = MAX_POSTPONE;
`else
    localparam int URG = 1;
`endif
    localparam int SAT = URG + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ddr3_refresh_scheduler_if bus ();

    ddr3_refresh_scheduler #(
        .TREFI        (TREFI),
        .TRFC         (TRFC),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        bit is_ref;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: refresh obligations counted arithmetically from the
    // INIT_DONE run length, scheduler availability tracked as "next decision
    // edge" timestamps rather than a state machine.
    int cyc        = 0;
    int m_run      = 0;
    int m_pend     = 0;
    int m_decide   = 0;
    int m_last_ref = -100;
    bit m_err      = 0;
    bit m_hold     = 0;
    bit m_block    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit tick;
        bit sref;
        int pend_old;
        cyc++;
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_err = 0; m_hold = 0; m_block = 0;
            m_decide = 0; m_last_ref = -100;
            exp_q.delete();
        end else begin
            pend_old = m_pend;
            sref = (m_last_ref == cyc - 1);
            tick = 0;
            if (bus.INIT_DONE) begin
                m_run++;
                tick = ((m_run % TREFI) == 0);
            end else begin
                m_run = 0;
            end
            if (cyc >= m_decide) begin
                if ((m_hold && bus.IDLE) || (!m_hold && pend_old > 0 && bus.IDLE)) begin
                    exp_q.push_back('{is_ref: 1'b1, cyc: cyc});
                    m_last_ref = cyc;
                    m_decide   = cyc + TRFC + 1;
                    m_hold     = 0;
                end else if (!m_hold && pend_old >= URG && bus.BANK_OPEN) begin
                    exp_q.push_back('{is_ref: 1'b0, cyc: cyc});
                    m_hold   = 1;
                    m_decide = cyc + 2;
                end else if (!m_hold && pend_old >= URG) begin
                    m_hold   = 1;
                    m_decide = cyc + 1;
                end
            end
            if (tick && !sref) begin
                if (m_pend == SAT) m_err = 1;
                else m_pend++;
            end else if (sref && !tick && m_pend > 0) begin
                m_pend--;
            end
            m_block = m_hold || ((cyc + 1 >= m_decide) && (m_pend >= URG));
        end
    end

    // Monitor: pops an expectation whenever REF or PRE is presented.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            chk("rst_ref",     int'(bus.REF),       0);
            chk("rst_pre",     int'(bus.PRE),       0);
            chk("rst_block",   int'(bus.REF_BLOCK), 0);
            chk("rst_pending", int'(bus.PENDING),   0);
            chk("rst_err",     int'(bus.REF_ERR),   0);
        end else begin
            if (bus.REF && bus.PRE) chk("ref_pre_overlap", 1, 0);
            if (bus.REF || bus.PRE) begin
                if (exp_q.size() == 0) begin
                    chk(bus.REF ? "unexpected_ref" : "unexpected_pre", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_is_ref", int'(bus.REF), int'(e.is_ref));
                    chk("pulse_cycle", cyc, e.cyc);
                    $display("pulse %s at cycle %0d pending=%0d", bus.REF ? "REF" : "PRE",
                             cyc, bus.PENDING);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk(e.is_ref ? "missed_ref" : "missed_pre", 0, 1);
            end
            chk("pending",   int'(bus.PENDING),   m_pend);
            chk("ref_block", int'(bus.REF_BLOCK), int'(m_block));
            chk("ref_err",   int'(bus.REF_ERR),   int'(m_err));
        end
    end

    task automatic set_in(input bit init, input bit idle, input bit bank);
        bus.INIT_DONE = init;
        bus.IDLE      = idle;
        bus.BANK_OPEN = bank;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int mode;
        int len;
        bit seen;
        set_in(0, 0, 0);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;

        // Basic issue with the controller idle.
        set_in(1, 1, 0);
        run(TREFI * 3);

        // Postpone with a bank open, then let the backlog drain.
        set_in(1, 0, 1);
        run(TREFI * 8 + 2);
        set_in(1, 0, 0);
        run(3);
        set_in(1, 1, 0);
        run((TRFC + 1) * 10 + 20);

        // Saturation: neither idle nor bank open.
        set_in(1, 0, 0);
        run(TREFI * 11);
        set_in(1, 1, 0);
        run(TREFI * 6);

        // Reset in the middle of a refresh.
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            run(1);
            seen = bus.REF;
        end
        if (!seen) chk("wait_ref_timeout", 0, 1);
        run(3);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        set_in(1, 1, 0);
        run(TREFI * 2 + 5);

        // Randomized controller behaviour.
        for (int k = 0; k < 60; k++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(1, 50);
            set_in(($urandom_range(0, 19) != 0), mode == 0, mode == 1);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                run(1);
                rst_n = 1'b1;
            end
            run(len);
        end

        set_in(1, 1, 0);
        run(TRFC * 3);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_refresh_scheduler.md
# ddr3_refresh_scheduler

Generates refresh traffic for the DDR3 command state machine. Counts tREFI intervals, keeps a count of owed refreshes, and issues REF opportunistically whenever the controller sits in Idle. When the postponement limit is reached it forces a precharge and blocks new activates until the refresh goes out. It sits directly upstream of the command state machine and drives that machine's REF and PRE request inputs.

## Interface
Parameters:
- TREFI, 780: refresh interval in CLK cycles (7.8 us at 100 MHz); must be ≥ 4.
- TRFC, 10: refresh cycle time in CLK cycles; must match the controller's Refresh_Wait length.
- MAX_POSTPONE, 8: owed refreshes tolerated before forcing (JEDEC limit).

Ports:
- CLK  in  1  controller clock.
- RESET  in  1  asynchronous, active-low reset.
- INIT_DONE  in  1  controller has left Initialization/ZQ_Calibration; the tREFI timer runs only while high.
- IDLE  in  1  controller is in Idle (all banks precharged).
- BANK_OPEN  in  1  controller is in Bank_Active, Reading, Writing or the AP variants.
- REF  out  1  one-cycle refresh request to the controller.
- PRE  out  1  one-cycle precharge request (forced refresh only).
- REF_BLOCK  out  1  tells the traffic source to stop issuing ACT/READ/WRITE.
- PENDING  out  4  number of owed refreshes, 0..MAX_POSTPONE+1.
- REF_ERR  out  1  sticky flag: a refresh was lost because PENDING was saturated.

## Operation
- Tick timer: counts 0..TREFI-1 while INIT_DONE=1 and wraps. The tick fires on the wrap. While INIT_DONE=0 the timer holds 0.
- PENDING counter:
  - +1 on a tick.
  - −1 in the S_REF cycle.
  - Tick and S_REF in the same cycle: unchanged.
  - Saturates at MAX_POSTPONE+1. A tick at saturation sets REF_ERR, which is cleared only by reset.
- Urgent condition: PENDING ≥ MAX_POSTPONE.
- FSM states: S_READY, S_PRE, S_WAIT, S_REF, S_TRFC.
  - S_READY:
    - PENDING>0 and IDLE → S_REF.
    - Else urgent and BANK_OPEN → S_PRE.
    - Else urgent and neither IDLE nor BANK_OPEN → S_WAIT.
    - Otherwise stay.
  - S_PRE: one cycle → S_WAIT.
  - S_WAIT: stay until IDLE, then → S_REF.
  - S_REF: one cycle; the TRFC counter loads TRFC-1 → S_TRFC.
  - S_TRFC: counts down to 0 → S_READY. IDLE is ignored during this state, because the controller is in Refreshing/Refresh_Wait.
- Outputs are Moore, decoded from the state register:
  - REF=1 in S_REF.
  - PRE=1 in S_PRE.
  - REF_BLOCK=1 in S_PRE and S_WAIT, and also in S_READY while urgent.
- Reset values: REF=0, PRE=0, REF_BLOCK=0, PENDING=0, REF_ERR=0, state S_READY, tick timer 0, TRFC counter 0.
- Reset mid-operation (any state) returns immediately to S_READY with all owed refreshes discarded.

## Timing
- Tick timing: the first tick comes TREFI cycles after INIT_DONE rises. PENDING updates in the cycle after the tick edge.
- Issue latency: with PENDING>0 and IDLE=1 sampled at edge n, REF is high in cycle n+1, and PENDING decrements at the end of that cycle.
- Forced path: urgent with BANK_OPEN at edge n gives PRE in cycle n+1. REF follows one cycle after IDLE is first sampled high.
- Back-to-back refreshes: consecutive REF pulses are spaced exactly TRFC+1 cycles apart when IDLE stays high.
- REF and PRE are never high in the same cycle. Each is high for exactly one cycle per entry.

## Configuration
- REF_POSTPONE_EN defined: opportunistic postponement up to MAX_POSTPONE, as described above.
- Undefined: the urgent threshold is 1 and PENDING saturates at 2. Every tick immediately forces PRE (if a bank is open), asserts REF_BLOCK, and issues REF. MAX_POSTPONE is ignored.

## Structure
- Shared package ddr3_ctrl_pkg holds:
  - the FSM state enum;
  - the default DDR3 timing constants (TREFI, TRFC, MAX_POSTPONE);
  - the PENDING width constant.
- Sub-module ddr3_refi_timer: the tREFI wrap counter with enable; it outputs a one-cycle tick.
- The scheduler FSM, PENDING counter and TRFC counter live in the top module.

## Test plan
- Basic issue: TREFI=20, TRFC=10, IDLE=1, BANK_OPEN=0; raise INIT_DONE → PENDING goes 0→1 after 20 cycles, REF pulses one cycle later, PENDING returns to 0, no PRE.
- Postpone then drain: BANK_OPEN=1, IDLE=0 for 8 ticks → PENDING=8, PRE pulses once, REF_BLOCK=1. Raise IDLE 3 cycles later → REF follows, and the remaining refreshes drain with REF spaced 11 cycles apart; REF_BLOCK drops when PENDING<8.
- Saturation: IDLE=0, BANK_OPEN=0 for 10 ticks → PENDING=9, REF_ERR=1 and sticky, S_WAIT held, no PRE.
- Collision: tick coincides with the S_REF cycle at PENDING=2 → PENDING stays 2.
- Reset mid-S_TRFC with PENDING=3: deassert RESET → all outputs 0 on the same edge; after release, the first REF waits a full TREFI.
- Macro off (REF_POSTPONE_EN undefined), BANK_OPEN=1: first tick → PRE next cycle, REF_BLOCK=1, REF after IDLE rises; PENDING never exceeds 2.
